// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect and halt; one-cycle memory read latency.
// Decode backpressure via instr_ready stalls the PC and holds instr/instr_pc steady.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 14,
  parameter int                OPC_W    = 4,
  parameter logic [OPC_W-1:0]  HALT_OPC = '1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  logic [ADDR_W-1:0] pc;
  logic              advance;
  logic              transfer;
  logic              halt_hit;

  assign advance   = !instr_valid || instr_ready;
  // rst_n gates the read so nothing is fetched while reset is held.
  assign imem_en   = rst_n && advance && !halted && !redirect_valid;
  assign imem_addr = pc;
  assign instr     = imem_rdata;

  assign transfer  = instr_valid && instr_ready;
  assign halt_hit  = transfer && (imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_target;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (imem_en) begin
        pc          <= pc + ADDR_W'(1);
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= instr_valid && !instr_ready;
      end
      // The word fetched alongside the halt transfer is dropped here.
      if (halt_hit) begin
        halted      <= 1'b1;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences, and a randomized run
// checked against a stream-level model of which instruction must be delivered next.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 14;
  localparam int OW = 4;
  localparam logic [OW-1:0] HALT = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          halted;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [256];
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rn, input logic rv, input logic [AW-1:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    rst_n = rn; redirect_valid = rv; redirect_target = tgt; instr_ready = rdy;
    @(negedge clk);
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] tgt;
    logic          rdy;
    logic          en;
    logic [AW-1:0] addr;
    logic          v;
    logic [AW-1:0] ipc;
  } vec_t;

  vec_t tbl[18];

  logic [AW-1:0] exp_pc;
  logic          mh;
  logic          hold_pend;
  logic [AW-1:0] hold_pc;
  logic [IW-1:0] hold_instr;
  int            xfers;
  logic          rv_r;
  logic [AW-1:0] tgt_r;
  logic          rdy_r;

  initial begin
    for (int i = 0; i < 256; i++) rom[i[7:0]] = IW'(i);

    //                rv    tgt    rdy   en    addr   v     ipc
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h01};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h02};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h03};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 8'h04};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 8'h05};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 8'h05};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 8'h05};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 8'h05};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 8'h06};
    tbl[11] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h08, 1'b1, 8'h07};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 8'h07};
    tbl[13] = '{1'b1, 8'h40, 1'b1, 1'b0, 8'h11, 1'b1, 8'h10};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h10};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b1, 8'h40};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 1'b1, 8'h41};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b1, 8'h41};

    // Reset state
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(imem_addr), 0);

    // Vector table: streaming, 3-cycle stall, two redirects
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
      chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_ipc", i), 32'(instr_pc), 32'(tbl[i].ipc));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 0);
      if (tbl[i].v) chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].ipc));
    end

    // PC wrap from 0xFE
    cyc(1'b1, 1'b1, 8'hFE, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("wrap_gap_valid", 32'(instr_valid), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("wrap_fe_valid", 32'(instr_valid), 1);
    chk("wrap_fe_pc", 32'(instr_pc), 32'h0FE);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("wrap_ff_pc", 32'(instr_pc), 32'h0FF);
    chk("wrap_ff_instr", 32'(instr), 32'h0FF);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("wrap_00_valid", 32'(instr_valid), 1);
    chk("wrap_00_pc", 32'(instr_pc), 0);
    chk("wrap_00_instr", 32'(instr), 0);

    // Halt at 0x03, then redirect out
    rom[3] = {HALT, 10'h003};
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("halt_seq%0d_valid", k), 32'(instr_valid), 1);
      chk($sformatf("halt_seq%0d_pc", k), 32'(instr_pc), 32'(k));
      chk($sformatf("halt_seq%0d_halted", k), 32'(halted), 0);
    end
    chk("halt_instr", 32'(instr), 32'({HALT, 10'h003}));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("halted%0d_flag", k), 32'(halted), 1);
      chk($sformatf("halted%0d_valid", k), 32'(instr_valid), 0);
      chk($sformatf("halted%0d_en", k), 32'(imem_en), 0);
    end
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    chk("unhalt_redir_en", 32'(imem_en), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("unhalt_flag", 32'(halted), 0);
    chk("unhalt_en", 32'(imem_en), 1);
    chk("unhalt_addr", 32'(imem_addr), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("unhalt_valid", 32'(instr_valid), 1);
    chk("unhalt_pc", 32'(instr_pc), 0);
    rom[3] = IW'(3);

    // Reset during a stalled valid output
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stallrst_pre_valid", 32'(instr_valid), 1);
    chk("stallrst_pre_pc", 32'(instr_pc), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("stallrst_en_low", 32'(imem_en), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stallrst_valid", 32'(instr_valid), 0);
    chk("stallrst_addr", 32'(imem_addr), 0);
    chk("stallrst_ipc", 32'(instr_pc), 0);
    chk("stallrst_en", 32'(imem_en), 1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("stallrst_first_valid", 32'(instr_valid), 1);
    chk("stallrst_first_pc", 32'(instr_pc), 0);

    // Randomized run against the delivered-stream model
    for (int i = 0; i < 256; i++) rom[i[7:0]] = IW'($urandom);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    exp_pc = 8'h00;
    mh = 1'b0;
    hold_pend = 1'b0;
    hold_pc = '0;
    hold_instr = '0;
    xfers = 0;
    for (int n = 0; n < 3000; n++) begin
      rv_r  = ($urandom_range(0, 11) == 0);
      tgt_r = AW'($urandom);
      rdy_r = ($urandom_range(0, 3) != 0);
      cyc(1'b1, rv_r, tgt_r, rdy_r);
      if (hold_pend) begin
        chk("rnd_hold_valid", 32'(instr_valid), 1);
        chk("rnd_hold_pc", 32'(instr_pc), 32'(hold_pc));
        chk("rnd_hold_instr", 32'(instr), 32'(hold_instr));
      end
      chk("rnd_halted", 32'(halted), 32'(mh));
      if (mh) begin
        chk("rnd_halt_valid", 32'(instr_valid), 0);
        chk("rnd_halt_en", 32'(imem_en), 0);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        chk("rnd_xfer_pc", 32'(instr_pc), 32'(exp_pc));
        chk("rnd_xfer_instr", 32'(instr), 32'(rom[exp_pc]));
        xfers++;
        if (rom[exp_pc][IW-1 -: OW] == HALT) mh = 1'b1;
        else exp_pc = exp_pc + 8'h01;
      end
      hold_pend  = instr_valid && !instr_ready && !redirect_valid;
      hold_pc    = instr_pc;
      hold_instr = instr;
      if (redirect_valid) begin
        exp_pc = redirect_target;
        mh = 1'b0;
      end
    end
    chk("rnd_progress", 32'(xfers > 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
